// File: rtl/data_mem_ctrl.sv
// Data memory controller: request/response handshake, byte/half/word
// little-endian accesses with sign/zero extension, fixed response latency
// (LAT = 1..4 clocks) and error reporting for illegal requests.
module data_mem_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              RespValid,
  output logic [31:0]       ReadData,
  output logic              Err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        pend_data, pend_data_d;
  logic               pend_err, pend_err_d;
  logic               resp_valid_d;
  logic [31:0]        read_data_d;
  logic               err_d;
  logic               ready_d;

  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic [ADDR_W-3:0]  word_addr;
  logic [IDX_W-1:0]   idx;
  logic               addr_oor;
  logic               misaligned;
  logic               req_err;
  logic [31:0]        rd_word;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_val;
  logic [31:0]        req_data;
  logic [3:0]         be;
  logic [31:0]        wdata_rep;
  logic               we;

  assign accept     = ReqValid && ReqReady;
  assign word_addr  = Address[ADDR_W-1:2];
  assign idx        = word_addr[IDX_W-1:0];
  assign addr_oor   = ({2'b00, word_addr} >= ADDR_W'(DEPTH));
  assign misaligned = ((Size == 2'b01) && Address[0]) ||
                      ((Size == 2'b10) && (Address[1:0] != 2'b00));
  assign req_err    = (Size == 2'b11) || misaligned || addr_oor || (MemRead && MemWrite);
  assign rd_word    = mem[idx];
  assign req_data   = (req_err || !MemRead) ? 32'h0 : load_val;
  assign we         = accept && MemWrite && !req_err;

  // Lane selection for loads, byte enables and replicated data for stores
  always_comb begin
    lane_b    = 8'h0;
    lane_h    = 16'h0;
    load_val  = 32'h0;
    be        = 4'b0000;
    wdata_rep = 32'h0;
    case (Size)
      2'b00: begin
        lane_b    = rd_word[{Address[1:0], 3'b000} +: 8];
        load_val  = Unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        be        = 4'b0001 << Address[1:0];
        wdata_rep = {4{WriteData[7:0]}};
      end
      2'b01: begin
        lane_h    = rd_word[{Address[1], 4'b0000} +: 16];
        load_val  = Unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        be        = Address[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{WriteData[15:0]}};
      end
      2'b10: begin
        load_val  = rd_word;
        be        = 4'b1111;
        wdata_rep = WriteData;
      end
      default: begin
        load_val  = 32'h0;
      end
    endcase
  end

  // Storage array: byte-granular commit at the accept edge, never reset
  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // State register with registered outputs; reset drops any pending response
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_data <= 32'h0;
      pend_err  <= 1'b0;
      RespValid <= 1'b0;
      ReadData  <= 32'h0;
      Err       <= 1'b0;
      ReqReady  <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pend_data <= pend_data_d;
      pend_err  <= pend_err_d;
      RespValid <= resp_valid_d;
      ReadData  <= read_data_d;
      Err       <= err_d;
      ReqReady  <= ready_d;
    end
  end

  // Next state: count down LAT-1 wait edges, capture the result on accept
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pend_data_d = pend_data;
    pend_err_d  = pend_err;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          pend_data_d = req_data;
          pend_err_d  = req_err;
          if (LAT > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: one-cycle response strobe, data/err zero outside the strobe
  always_comb begin
    resp_valid_d = 1'b0;
    read_data_d  = 32'h0;
    err_d        = 1'b0;
    if ((state == ST_IDLE) && accept && (LAT == 1)) begin
      resp_valid_d = 1'b1;
      read_data_d  = req_data;
      err_d        = req_err;
    end else if ((state == ST_WAIT) && (cnt == CNT_W'(1))) begin
      resp_valid_d = 1'b1;
      read_data_d  = pend_data;
      err_d        = pend_err;
    end
    ready_d = (state_d == ST_IDLE) || resp_valid_d;
  end

endmodule
